// File: rtl/sat_add_arbiter_if.sv
// Handshake bundle for the shared saturating adder: two requester ports,
// one result port and the saturation statistics counter.
interface sat_add_arbiter_if #(
   parameter int W     = 4,
   parameter int CNT_W = 8
);
   logic                 req0_vld;
   logic                 req0_rdy;
   logic signed [W-1:0]  req0_a;
   logic signed [W-1:0]  req0_b;
   logic                 req1_vld;
   logic                 req1_rdy;
   logic signed [W-1:0]  req1_a;
   logic signed [W-1:0]  req1_b;
   logic                 res_vld;
   logic                 res_rdy;
   logic signed [W-1:0]  res_sum;
   logic                 res_id;
   logic                 res_sat;
   logic [CNT_W-1:0]     sat_cnt;

   modport slave (
      input  req0_vld, req0_a, req0_b,
      input  req1_vld, req1_a, req1_b,
      input  res_rdy,
      output req0_rdy, req1_rdy,
      output res_vld, res_sum, res_id, res_sat, sat_cnt
   );

   modport master (
      output req0_vld, req0_a, req0_b,
      output req1_vld, req1_a, req1_b,
      output res_rdy,
      input  req0_rdy, req1_rdy,
      input  res_vld, res_sum, res_id, res_sat, sat_cnt
   );
endinterface

// File: rtl/sat_add_arbiter.sv
// Round-robin shared signed saturating adder with a one-entry registered
// result buffer tagged by source port, plus a sticky saturation counter.
module sat_add_arbiter #(
   parameter int W     = 4,
   parameter int CNT_W = 8
) (
   input logic               clk,
   input logic               rst,
   sat_add_arbiter_if.slave  bus
);

   // Returns {overflow, clamped_sum}.
   function automatic logic [W:0] sat_add(input logic signed [W-1:0] a,
                                          input logic signed [W-1:0] b);
      logic signed [W-1:0] raw;
      logic                ovf;
      raw = a + b;
      ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
      if (ovf)
         raw = a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      return {ovf, raw};
   endfunction

   function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   logic                r_res_vld;
   logic signed [W-1:0] r_res_sum;
   logic                r_res_id;
   logic                r_res_sat;
   logic                r_last_grant;
   logic [CNT_W-1:0]    r_sat_cnt;

   logic                w_can_accept;
   logic                w_gnt_vld;
   logic                w_gnt_id;
   logic                w_accept;
   logic signed [W-1:0] w_op_a;
   logic signed [W-1:0] w_op_b;
   logic [W:0]          w_sat_res;

   // The buffer can take a new result when empty or being drained this cycle.
   assign w_can_accept = !r_res_vld || bus.res_rdy;

   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt_id  = 1'b0;
      if (bus.req0_vld && bus.req1_vld) begin
         w_gnt_vld = 1'b1;
         w_gnt_id  = ~r_last_grant;
      end else if (bus.req0_vld) begin
         w_gnt_vld = 1'b1;
         w_gnt_id  = 1'b0;
      end else if (bus.req1_vld) begin
         w_gnt_vld = 1'b1;
         w_gnt_id  = 1'b1;
      end
   end

   assign w_accept     = w_can_accept && w_gnt_vld;
   assign bus.req0_rdy = w_can_accept && w_gnt_vld && !w_gnt_id;
   assign bus.req1_rdy = w_can_accept && w_gnt_vld && w_gnt_id;

   assign w_op_a    = w_gnt_id ? bus.req1_a : bus.req0_a;
   assign w_op_b    = w_gnt_id ? bus.req1_b : bus.req0_b;
   assign w_sat_res = sat_add(w_op_a, w_op_b);

   // Result register: refill on accept, otherwise only the valid flag drains.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_res_vld    <= 1'b0;
         r_res_sum    <= '0;
         r_res_id     <= 1'b0;
         r_res_sat    <= 1'b0;
         r_last_grant <= 1'b1;
         r_sat_cnt    <= '0;
      end else if (w_accept) begin
         r_res_vld    <= 1'b1;
         r_res_sum    <= w_sat_res[W-1:0];
         r_res_id     <= w_gnt_id;
         r_res_sat    <= w_sat_res[W];
         r_last_grant <= w_gnt_id;
         if (w_sat_res[W])
            r_sat_cnt <= cnt_inc(r_sat_cnt);
      end else if (bus.res_rdy) begin
         r_res_vld <= 1'b0;
      end
   end

   assign bus.res_vld = r_res_vld;
   assign bus.res_sum = r_res_sum;
   assign bus.res_id  = r_res_id;
   assign bus.res_sat = r_res_sat;
   assign bus.sat_cnt = r_sat_cnt;

endmodule

// File: tb/tb_sat_add_arbiter.sv
// Scoreboard bench for sat_add_arbiter: a behavioural arbiter/adder model
// predicts ready, results and counters; a second instance uses CNT_W=2.
module tb_sat_add_arbiter;
   localparam int W    = 4;
   localparam int MAXV = 2**(W-1) - 1;
   localparam int MINV = -(2**(W-1));

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sat_add_arbiter_if #(.W(W), .CNT_W(8)) bus ();
   sat_add_arbiter_if #(.W(W), .CNT_W(2)) bus2 ();

   assign bus2.req0_vld = bus.req0_vld;
   assign bus2.req0_a   = bus.req0_a;
   assign bus2.req0_b   = bus.req0_b;
   assign bus2.req1_vld = bus.req1_vld;
   assign bus2.req1_a   = bus.req1_a;
   assign bus2.req1_b   = bus.req1_b;
   assign bus2.res_rdy  = bus.res_rdy;

   sat_add_arbiter #(.W(W), .CNT_W(8)) dut  (.clk(clk), .rst(rst), .bus(bus));
   sat_add_arbiter #(.W(W), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   typedef struct {
      int id;
      int sum;
      int sat;
   } exp_t;

   exp_t exp_q[$];
   int   m_vld, m_last, m_cnt, m_cnt2;

   always @(negedge clk) begin
      if (rst) begin
         m_vld  = 0;
         m_last = 1;
         m_cnt  = 0;
         m_cnt2 = 0;
         exp_q.delete();
      end else begin
         int   v0, v1, can, gv, gid, s, cl;
         exp_t e;
         chk("res_vld", bus.res_vld, m_vld);
         chk("sat_cnt", bus.sat_cnt, m_cnt);
         chk("sat_cnt_w2", bus2.sat_cnt, m_cnt2);
         if (m_vld != 0 && bus.res_rdy) begin
            if (exp_q.size() == 0)
               chk("unexpected_result", exp_q.size(), 1);
            else begin
               e = exp_q.pop_front();
               chk("res_id", bus.res_id, e.id);
               chk("res_sum", bus.res_sum, e.sum);
               chk("res_sat", bus.res_sat, e.sat);
            end
         end
         v0  = bus.req0_vld;
         v1  = bus.req1_vld;
         can = (m_vld == 0) || bus.res_rdy;
         gv  = v0 | v1;
         gid = (v0 != 0 && v1 != 0) ? ((m_last != 0) ? 0 : 1) : v1;
         chk("req0_rdy", bus.req0_rdy, int'(can != 0 && gv != 0 && gid == 0));
         chk("req1_rdy", bus.req1_rdy, int'(can != 0 && gv != 0 && gid == 1));
         if (can != 0 && gv != 0) begin
            if (gid != 0) s = int'(bus.req1_a) + int'(bus.req1_b);
            else          s = int'(bus.req0_a) + int'(bus.req0_b);
            cl    = int'(s > MAXV || s < MINV);
            e.id  = gid;
            e.sum = (s > MAXV) ? MAXV : ((s < MINV) ? MINV : s);
            e.sat = cl;
            exp_q.push_back(e);
            m_last = gid;
            m_vld  = 1;
            if (cl != 0) begin
               if (m_cnt < 255) m_cnt++;
               if (m_cnt2 < 3)  m_cnt2++;
            end
         end else if (bus.res_rdy) begin
            m_vld = 0;
         end
      end
   end

   task automatic cyc(input bit v0, input int a0, input int b0,
                      input bit v1, input int a1, input int b1, input bit rr);
      bus.req0_vld = v0;
      bus.req0_a   = a0[W-1:0];
      bus.req0_b   = b0[W-1:0];
      bus.req1_vld = v1;
      bus.req1_a   = a1[W-1:0];
      bus.req1_b   = b1[W-1:0];
      bus.res_rdy  = rr;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 1);
   endtask

   initial begin
      int cap_sum, cap_id;
      int cnt_exp[5];
      int ops[5][2];
      cnt_exp = '{1, 2, 3, 3, 3};
      ops     = '{'{7, 4}, '{-7, -4}, '{4, 4}, '{-4, -4}, '{6, 3}};

      bus.req0_vld = 0; bus.req0_a = '0; bus.req0_b = '0;
      bus.req1_vld = 0; bus.req1_a = '0; bus.req1_b = '0;
      bus.res_rdy  = 1;
      @(posedge clk); #1;
      chk("rst_res_vld", bus.res_vld, 0);
      chk("rst_res_sum", bus.res_sum, 0);
      chk("rst_res_id",  bus.res_id, 0);
      chk("rst_res_sat", bus.res_sat, 0);
      chk("rst_sat_cnt", bus.sat_cnt, 0);
      @(posedge clk); #1;
      rst = 0;
      idle(1);

      // Single requester on port 0
      cyc(1, 4, 7, 0, 0, 0, 1);
      chk("p0_sum_a", bus.res_sum, 7);
      chk("p0_sat_a", bus.res_sat, 1);
      chk("p0_id_a",  bus.res_id, 0);
      cyc(1, 1, -2, 0, 0, 0, 1);
      chk("p0_sum_b", bus.res_sum, -1);
      chk("p0_sat_b", bus.res_sat, 0);
      idle(2);

      // Both requesting: strict alternation
      for (int i = 0; i < 6; i++) begin
         cyc(1, -4, -7, 1, 3, -5, 1);
         chk("alt_sum", bus.res_sum, (bus.res_id != 0) ? -2 : -8);
         chk("alt_sat", bus.res_sat, (bus.res_id != 0) ? 0 : 1);
      end
      idle(2);

      // Backpressure: result held, no grants, then drain+refill
      cyc(1, 2, 3, 1, -1, -1, 1);
      cap_sum = bus.res_sum;
      cap_id  = bus.res_id;
      for (int i = 0; i < 3; i++) begin
         cyc(1, 2, 3, 1, -1, -1, 0);
         chk("hold_sum", bus.res_sum, cap_sum);
         chk("hold_id",  bus.res_id, cap_id);
         chk("hold_rdy", int'(bus.req0_rdy) + int'(bus.req1_rdy), 0);
      end
      cyc(1, 2, 3, 1, -1, -1, 1);
      chk("refill_vld", bus.res_vld, 1);
      chk("refill_id",  bus.res_id, 1 - cap_id);
      idle(2);

      // Sticky saturation counter on the 2-bit instance
      rst = 1;
      idle(1);
      rst = 0;
      for (int i = 0; i < 5; i++) begin
         cyc(1, ops[i][0], ops[i][1], 0, 0, 0, 1);
         chk("cnt_w2", bus2.sat_cnt, cnt_exp[i]);
      end
      idle(2);

      // Exhaustive operand sweep through port 1
      for (int a = MINV; a <= MAXV; a++)
         for (int b = MINV; b <= MAXV; b++)
            cyc(0, 0, 0, 1, a, b, 1);
      idle(2);

      // Asynchronous reset while a result is held
      cyc(1, 5, 1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      chk("pre_rst_vld", bus.res_vld, 1);
      #2;
      rst = 1;
      #1;
      chk("arst_res_vld", bus.res_vld, 0);
      chk("arst_res_sum", bus.res_sum, 0);
      chk("arst_res_id",  bus.res_id, 0);
      chk("arst_res_sat", bus.res_sat, 0);
      chk("arst_sat_cnt", bus.sat_cnt, 0);
      bus.req0_vld = 1; bus.req0_a = 4'sd2; bus.req0_b = 4'sd2;
      bus.req1_vld = 1; bus.req1_a = 4'sd1; bus.req1_b = 4'sd1;
      bus.res_rdy  = 1;
      @(posedge clk); #1;
      rst = 0;
      #1;
      chk("tie_rdy0", bus.req0_rdy, 1);
      chk("tie_rdy1", bus.req1_rdy, 0);
      @(posedge clk); #1;
      chk("tie_id", bus.res_id, 0);
      cyc(1, 2, 2, 1, 1, 1, 1);
      chk("tie_next_id", bus.res_id, 1);
      idle(3);

      chk("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
